// File: rtl/pipeline_pkg.sv
// Shared pipeline types and defaults.
// Holds PC unit widths and the RUN/HALTED state encoding.
package pipeline_pkg;

  localparam int PC_SZ_DEF      = 32;
  localparam int INST_BYTES_DEF = 4;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } pc_state_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack.
// Ports: i_clk, i_reset, i_push/i_pop with i_data, o_top,
// o_empty/o_full, sticky o_ovf (push over full), o_unf (pop on empty).
module ras_stack
  import pipeline_pkg::*;
#(
  parameter int DW     = PC_SZ_DEF,
  parameter int DEPTH  = 4,
  parameter int PTR_SZ = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_top,
  output logic          o_empty,
  output logic          o_full,
  output logic          o_ovf,
  output logic          o_unf
);

  localparam logic [PTR_SZ:0] CNT_MAX =
    (PTR_SZ+1)'(DEPTH);

  logic [DW-1:0]     mem [DEPTH];
  logic [PTR_SZ-1:0] ptr;
  logic [PTR_SZ-1:0] top_idx;
  logic [PTR_SZ:0]   cnt;

  // ptr is the next free slot; top is one below it
  assign top_idx = ptr - PTR_SZ'(1);
  assign o_top   = mem[top_idx];
  assign o_empty = (cnt == '0);
  assign o_full  = (cnt == CNT_MAX);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      ptr   <= '0;
      cnt   <= '0;
      o_ovf <= 1'b0;
      o_unf <= 1'b0;
    end else if (i_push) begin
      // when full, ptr already sits on the
      // oldest entry, so this overwrites it
      mem[ptr] <= i_data;
      ptr      <= ptr + PTR_SZ'(1);
      if (o_full)
        o_ovf <= 1'b1;
      else
        cnt <= cnt + 1'b1;
    end else if (i_pop) begin
      if (o_empty) begin
        o_unf <= 1'b1;
      end else begin
        ptr <= top_idx;
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// IF-stage program counter with next-PC select, RAS and halt/step.
// Ports: i_clk, i_reset, run/step gating, redirects, o_pc, o_pc_plus, status.
module pc_unit
  import pipeline_pkg::*;
#(
  parameter int                PC_SZ        = PC_SZ_DEF,
  parameter int                INST_BYTES   = INST_BYTES_DEF,
  parameter logic [PC_SZ-1:0]  RESET_VECTOR = '0,
  parameter int                RAS_DEPTH    = 4,
  parameter int                RAS_PTR_SZ   = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_step_mode,
  input  logic             i_step,
  input  logic             i_stall_pc_HD,
  input  logic             i_branch_taken,
  input  logic [PC_SZ-1:0] i_branch_addr,
  input  logic             i_jump,
  input  logic [PC_SZ-1:0] i_jump_addr,
  input  logic             i_call,
  input  logic             i_ret,
  input  logic             i_halt,
  output logic [PC_SZ-1:0] o_pc,
  output logic [PC_SZ-1:0] o_pc_plus,
  output logic             o_halted,
  output logic             o_ras_empty,
  output logic             o_ras_full,
  output logic             o_ras_ovf,
  output logic             o_ras_unf
);

  pc_state_e        state, state_nxt;
  logic [PC_SZ-1:0] pc_nxt;
  logic [PC_SZ-1:0] ras_top;
  logic             go;
  logic             push, pop;

  assign o_pc_plus = o_pc + PC_SZ'(INST_BYTES);
  assign o_halted  = (state == ST_HALTED);
  assign go = (state == ST_RUN) & i_enable &
              (~i_step_mode | i_step);

  always_comb begin
    pc_nxt    = o_pc;
    state_nxt = state;
    push      = 1'b0;
    pop       = 1'b0;
    if (i_branch_taken && go) begin
      // flush redirect overrides a stall
      pc_nxt = i_branch_addr;
    end else if (i_stall_pc_HD || !go) begin
      pc_nxt = o_pc;
    end else if (i_halt) begin
      state_nxt = ST_HALTED;
    end else if (i_ret) begin
      pop    = 1'b1;
      pc_nxt = o_ras_empty ? o_pc_plus : ras_top;
    end else if (i_jump) begin
      push   = i_call;
      pc_nxt = i_jump_addr;
    end else begin
      pc_nxt = o_pc_plus;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_pc  <= RESET_VECTOR;
      state <= ST_RUN;
    end else begin
      o_pc  <= pc_nxt;
      state <= state_nxt;
    end
  end

  ras_stack #(
    .DW     (PC_SZ),
    .DEPTH  (RAS_DEPTH),
    .PTR_SZ (RAS_PTR_SZ)
  ) u_ras (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push),
    .i_pop   (pop),
    .i_data  (o_pc_plus),
    .o_top   (ras_top),
    .o_empty (o_ras_empty),
    .o_full  (o_ras_full),
    .o_ovf   (o_ras_ovf),
    .o_unf   (o_ras_unf)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit.
// Inputs change between edges; outputs sampled 1 time unit after posedge.
module tb_pc_unit;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic        i_step_mode;
  logic        i_step;
  logic        i_stall_pc_HD;
  logic        i_branch_taken;
  logic [31:0] i_branch_addr;
  logic        i_jump;
  logic [31:0] i_jump_addr;
  logic        i_call;
  logic        i_ret;
  logic        i_halt;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus;
  logic        o_halted;
  logic        o_ras_empty;
  logic        o_ras_full;
  logic        o_ras_ovf;
  logic        o_ras_unf;

  int n_chk = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  pc_unit dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_step_mode    (i_step_mode),
    .i_step         (i_step),
    .i_stall_pc_HD  (i_stall_pc_HD),
    .i_branch_taken (i_branch_taken),
    .i_branch_addr  (i_branch_addr),
    .i_jump         (i_jump),
    .i_jump_addr    (i_jump_addr),
    .i_call         (i_call),
    .i_ret          (i_ret),
    .i_halt         (i_halt),
    .o_pc           (o_pc),
    .o_pc_plus      (o_pc_plus),
    .o_halted       (o_halted),
    .o_ras_empty    (o_ras_empty),
    .o_ras_full     (o_ras_full),
    .o_ras_ovf      (o_ras_ovf),
    .o_ras_unf      (o_ras_unf)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic idle();
    i_step         = 1'b0;
    i_stall_pc_HD  = 1'b0;
    i_branch_taken = 1'b0;
    i_branch_addr  = '0;
    i_jump         = 1'b0;
    i_jump_addr    = '0;
    i_call         = 1'b0;
    i_ret          = 1'b0;
    i_halt         = 1'b0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    idle();
    i_enable    = 1'b1;
    i_step_mode = 1'b0;
    i_reset     = 1'b1;
    #2;
    i_reset     = 1'b0;
  endtask

  task automatic call(input logic [31:0] a);
    i_jump = 1'b1; i_call = 1'b1;
    i_jump_addr = a;
    tick();
    idle();
  endtask

  task automatic ret();
    i_ret = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    // reset state
    idle();
    i_enable    = 1'b1;
    i_step_mode = 1'b0;
    i_reset     = 1'b1;
    #2;
    chk("rst_pc",    o_pc, 32'h0);
    chk("rst_halt",  32'(o_halted), 32'd0);
    chk("rst_empty", 32'(o_ras_empty), 32'd1);
    chk("rst_full",  32'(o_ras_full), 32'd0);
    chk("rst_ovf",   32'(o_ras_ovf), 32'd0);
    chk("rst_unf",   32'(o_ras_unf), 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;

    // free run 10 cycles
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("run%0d", k), o_pc, 32'(4*k));
    end
    chk("pc_plus", o_pc_plus, 32'h2C);

    // enable low holds
    i_enable = 1'b0;
    run_n(2);
    chk("en_hold", o_pc, 32'h28);
    i_enable = 1'b1;

    // stall at 0x10, then branch under stall
    do_reset();
    run_n(4);
    chk("at10", o_pc, 32'h10);
    i_stall_pc_HD = 1'b1;
    tick();
    chk("stall1", o_pc, 32'h10);
    tick();
    chk("stall2", o_pc, 32'h10);
    i_stall_pc_HD = 1'b0;
    tick();
    chk("unstall", o_pc, 32'h14);
    i_stall_pc_HD  = 1'b1;
    i_branch_taken = 1'b1;
    i_branch_addr  = 32'h80;
    tick();
    idle();
    chk("br_stall", o_pc, 32'h80);

    // call and ret; ret wins over jump
    do_reset();
    run_n(8);
    chk("at20", o_pc, 32'h20);
    call(32'h100);
    chk("call_pc", o_pc, 32'h100);
    chk("call_ne", 32'(o_ras_empty), 32'd0);
    tick();
    chk("at104", o_pc, 32'h104);
    i_jump = 1'b1;
    i_jump_addr = 32'h500;
    ret();
    chk("ret_pc", o_pc, 32'h24);
    chk("ret_emp", 32'(o_ras_empty), 32'd1);
    i_call = 1'b1;
    tick();
    idle();
    chk("call_nj", o_pc, 32'h28);
    chk("cnj_emp", 32'(o_ras_empty), 32'd1);

    // five calls into a depth-4 RAS
    do_reset();
    call(32'h100);
    call(32'h200);
    call(32'h300);
    call(32'h400);
    chk("full4", 32'(o_ras_full), 32'd1);
    chk("novf4", 32'(o_ras_ovf), 32'd0);
    call(32'h500);
    chk("ovf5", 32'(o_ras_ovf), 32'd1);
    chk("full5", 32'(o_ras_full), 32'd1);
    ret();
    chk("pop1", o_pc, 32'h404);
    chk("pop1f", 32'(o_ras_full), 32'd0);
    ret();
    chk("pop2", o_pc, 32'h304);
    ret();
    chk("pop3", o_pc, 32'h204);
    ret();
    chk("pop4", o_pc, 32'h104);
    chk("pop4e", 32'(o_ras_empty), 32'd1);
    chk("pop4u", 32'(o_ras_unf), 32'd0);
    ret();
    chk("unf_pc", o_pc, 32'h108);
    chk("unf", 32'(o_ras_unf), 32'd1);

    // step mode: pulses on cycles 2, 5, 8
    do_reset();
    i_step_mode = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      i_step = (c == 2 || c == 5 || c == 8);
      tick();
      if (c == 1) chk("st_c1", o_pc, 32'h0);
      if (c == 3) chk("st_c3", o_pc, 32'h4);
    end
    i_step = 1'b0;
    chk("st_end", o_pc, 32'hC);

    // address wrap
    do_reset();
    i_branch_taken = 1'b1;
    i_branch_addr  = 32'hFFFF_FFFC;
    tick();
    idle();
    chk("br_top", o_pc, 32'hFFFF_FFFC);
    chk("wrap_plus", o_pc_plus, 32'h0);
    tick();
    chk("wrap", o_pc, 32'h0);

    // halt at 0x30, frozen despite jump
    do_reset();
    run_n(12);
    chk("at30", o_pc, 32'h30);
    i_halt = 1'b1;
    tick();
    idle();
    chk("halt_pc", o_pc, 32'h30);
    chk("halted", 32'(o_halted), 32'd1);
    i_jump = 1'b1;
    i_jump_addr = 32'h900;
    run_n(5);
    chk("halt_frz", o_pc, 32'h30);
    idle();

    // asynchronous reset between edges
    #2;
    i_reset = 1'b1;
    #1;
    chk("arst_pc", o_pc, 32'h0);
    chk("arst_h", 32'(o_halted), 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    tick();
    chk("post_rst", o_pc, 32'h4);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
